// File: rtl/wave_ram_sequencer.sv
// Wave channel front end: two 16-byte wave RAM banks with CPU halfword access,
// plus the playback frequency timer, position counter, bank switching and
// length counter that feed one 4-bit sample per step downstream.
module wave_ram_sequencer #(
   parameter int unsigned TIMER_SCALE = 4,
   parameter int unsigned TIMER_W     = 14
) (
   input  logic        system_clock,
   input  logic        reset_n,
   input  logic [7:0]  nr30,
   input  logic [7:0]  nr31,
   input  logic [10:0] freq,
   input  logic        length_en,
   input  logic        trigger,
   input  logic        len_tick,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [1:0]  wr_be,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [3:0]  sample,
   output logic        sample_strobe,
   output logic        active
);

   localparam int unsigned POS_W   = 5;
   localparam int unsigned LEN_W   = 9;
   localparam int unsigned BYTES   = 16;
   localparam int unsigned FREQ_MAX = 2048;

   logic [7:0]         ram [2][BYTES];
   logic [POS_W-1:0]   position;
   logic               play_bank;
   logic [LEN_W-1:0]   length;
   logic [TIMER_W-1:0] timer;

   logic               cpu_bank_c;
   logic [TIMER_W-1:0] period_c;
   logic [POS_W-1:0]   next_pos_c;
   logic               next_bank_c;
   logic [7:0]         step_byte_c;
   logic [3:0]         step_sample_c;
   logic [7:0]         trig_byte_c;
   logic [LEN_W-1:0]   length_load_c;
   logic               unused_nr30_bits;

   // CPU always addresses the bank that is not selected for playback
   assign cpu_bank_c = ~nr30[6];

   // Reload value of the frequency timer; 2048 - freq never underflows
   assign period_c = TIMER_W'((32'(FREQ_MAX) - 32'(freq)) * TIMER_SCALE);

   // Length load value 256 - nr31, range 1..256
   assign length_load_c = LEN_W'(9'd256 - {1'b0, nr31});

   // Next playback position and bank; 64-sample mode flips bank on wrap
   assign next_pos_c  = position + POS_W'(1);
   assign next_bank_c = (position == POS_W'(31) && nr30[5]) ? ~play_bank : play_bank;

   // Playback reads see pre-write RAM contents (nonblocking RAM update)
   assign step_byte_c   = ram[next_bank_c][next_pos_c[4:1]];
   assign step_sample_c = next_pos_c[0] ? step_byte_c[3:0] : step_byte_c[7:4];
   assign trig_byte_c   = ram[nr30[6]][4'd0];

   assign unused_nr30_bits = ^nr30[4:0];

   // Wave RAM storage with per-byte CPU write enables into the CPU bank
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < BYTES; i++) begin
               ram[b][i] <= 8'h00;
            end
         end
      end else if (wr_en) begin
         if (wr_be[0]) ram[cpu_bank_c][{wr_addr, 1'b0}] <= wr_data[7:0];
         if (wr_be[1]) ram[cpu_bank_c][{wr_addr, 1'b1}] <= wr_data[15:8];
      end
   end

   // Registered CPU halfword read from the CPU bank
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= 16'h0000;
      end else begin
         rd_data <= {ram[cpu_bank_c][{rd_addr, 1'b1}], ram[cpu_bank_c][{rd_addr, 1'b0}]};
      end
   end

   // Playback control: disable > trigger > timer step / length expiry
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         active        <= 1'b0;
         sample        <= 4'h0;
         sample_strobe <= 1'b0;
         position      <= '0;
         play_bank     <= 1'b0;
         length        <= '0;
         timer         <= '0;
      end else begin
         sample_strobe <= 1'b0;
         if (!nr30[7]) begin
            active <= 1'b0;
            sample <= 4'h0;
         end else if (trigger) begin
            active        <= 1'b1;
            position      <= '0;
            play_bank     <= nr30[6];
            timer         <= period_c;
            length        <= length_load_c;
            sample        <= trig_byte_c[7:4];
            sample_strobe <= 1'b1;
         end else if (active) begin
            if (timer <= TIMER_W'(1)) begin
               timer         <= period_c;
               position      <= next_pos_c;
               play_bank     <= next_bank_c;
               sample        <= step_sample_c;
               sample_strobe <= 1'b1;
            end else begin
               timer <= timer - TIMER_W'(1);
            end
            if (len_tick && length_en && length != '0) begin
               length <= length - LEN_W'(1);
               if (length == LEN_W'(1)) begin
                  active        <= 1'b0;
                  sample        <= 4'h0;
                  sample_strobe <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_wave_ram_sequencer.sv
// Directed bench for wave_ram_sequencer with a sample scoreboard queue.
module tb_wave_ram_sequencer;

   logic        system_clock;
   logic        reset_n;
   logic [7:0]  nr30;
   logic [7:0]  nr31;
   logic [10:0] freq;
   logic        length_en;
   logic        trigger;
   logic        len_tick;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [3:0]  sample;
   logic        sample_strobe;
   logic        active;

   int passed = 0;
   int total  = 0;
   logic [3:0] exp_q [$];

   wave_ram_sequencer #(.TIMER_SCALE(4), .TIMER_W(14)) dut (
      .system_clock (system_clock),
      .reset_n      (reset_n),
      .nr30         (nr30),
      .nr31         (nr31),
      .freq         (freq),
      .length_en    (length_en),
      .trigger      (trigger),
      .len_tick     (len_tick),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_be        (wr_be),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .sample       (sample),
      .sample_strobe(sample_strobe),
      .active       (active)
   );

   initial system_clock = 1'b0;
   always #5 system_clock = ~system_clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge system_clock);
   endtask

   task automatic cpu_write(input logic [7:0] n30, input logic [2:0] a,
                            input logic [15:0] d, input logic [1:0] be);
      nr30 = n30; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      step();
      wr_en = 1'b0;
   endtask

   task automatic cpu_read(input string tag, input logic [7:0] n30,
                           input logic [2:0] a, input logic [15:0] exp);
      nr30 = n30; rd_addr = a;
      step();
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   // Trigger, then pop and compare n strobed samples and their spacing
   task automatic trigger_collect(input string tag, input int n);
      int got = 0;
      int last = -1;
      int cyc = 0;
      logic [3:0] e;
      trigger = 1'b1;
      while (got < n && cyc < n * 4 + 20) begin
         step();
         trigger = 1'b0;
         cyc++;
         if (sample_strobe) begin
            if (exp_q.size() == 0) begin
               check({tag, "_unexpected_strobe"}, 32'(got), 32'(n));
            end else begin
               e = exp_q.pop_front();
               check({tag, "_sample"}, 32'(sample), 32'(e));
            end
            if (last < 0) check({tag, "_first_latency"}, 32'(cyc), 32'd1);
            else          check({tag, "_interval"}, 32'(cyc - last), 32'd4);
            last = cyc;
            got++;
         end
      end
      check({tag, "_strobe_count"}, 32'(got), 32'(n));
   endtask

   initial begin
      int strobes;
      reset_n = 1'b0; nr30 = 8'h00; nr31 = 8'h00; freq = 11'd2047;
      length_en = 1'b0; trigger = 1'b0; len_tick = 1'b0; wr_en = 1'b0;
      wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b00; rd_addr = 3'd0;
      #12;
      check("reset_rd_data", 32'(rd_data), 32'd0);
      check("reset_sample", 32'(sample), 32'd0);
      check("reset_strobe", 32'(sample_strobe), 32'd0);
      check("reset_active", 32'(active), 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // Bank isolation: nr30[6]=1 puts the CPU on bank 0
      cpu_write(8'h40, 3'd0, 16'h1234, 2'b11);
      cpu_read("bank0_read", 8'h40, 3'd0, 16'h1234);
      cpu_read("bank1_isolated", 8'h00, 3'd0, 16'h0000);
      cpu_write(8'h40, 3'd1, 16'hBEEF, 2'b01);
      cpu_read("byte_enable_lo", 8'h40, 3'd1, 16'h00EF);
      cpu_write(8'h40, 3'd1, 16'hBEEF, 2'b10);
      cpu_read("byte_enable_hi", 8'h40, 3'd1, 16'hBEEF);

      // Sample order and step rate from bank 0
      cpu_write(8'h40, 3'd0, 16'hCDAB, 2'b11);
      nr30 = 8'h80; freq = 11'd2047;
      exp_q.push_back(4'hA); exp_q.push_back(4'hB);
      exp_q.push_back(4'hC); exp_q.push_back(4'hD);
      trigger_collect("order", 4);
      nr30 = 8'h00;
      step();
      check("disable_active", 32'(active), 32'd0);
      check("disable_sample", 32'(sample), 32'd0);

      // 64-sample mode: bank0 = 0x11, bank1 = 0x22, wraps across both banks
      for (int i = 0; i < 8; i++) cpu_write(8'h40, 3'(i), 16'h1111, 2'b11);
      for (int i = 0; i < 8; i++) cpu_write(8'h00, 3'(i), 16'h2222, 2'b11);
      nr30 = 8'hA0;
      exp_q.delete();
      for (int i = 0; i < 32; i++) exp_q.push_back(4'h1);
      for (int i = 0; i < 32; i++) exp_q.push_back(4'h2);
      exp_q.push_back(4'h1);
      trigger_collect("wrap64", 65);
      exp_q.delete();

      // Length expiry after two ticks with nr31 = 0xFE
      nr30 = 8'h80; nr31 = 8'hFE; length_en = 1'b1; trigger = 1'b1;
      step();
      trigger = 1'b0;
      len_tick = 1'b1; step(); len_tick = 1'b0;
      check("len_after_tick1", 32'(active), 32'd1);
      len_tick = 1'b1; step(); len_tick = 1'b0;
      check("len_expired_active", 32'(active), 32'd0);
      check("len_expired_sample", 32'(sample), 32'd0);

      // Length counter held while length_en = 0
      length_en = 1'b0; trigger = 1'b1;
      step();
      trigger = 1'b0;
      len_tick = 1'b1; step(); len_tick = 1'b0;
      len_tick = 1'b1; step(); len_tick = 1'b0;
      check("len_disabled_active", 32'(active), 32'd1);

      // Trigger coincident with timer expiry and len_tick
      cpu_write(8'h40, 3'd0, 16'h5634, 2'b11);
      nr30 = 8'h80; nr31 = 8'hFE; length_en = 1'b1; freq = 11'd2047;
      trigger = 1'b1; step(); trigger = 1'b0;          // edge E0
      step();                                            // N2
      len_tick = 1'b1; step(); len_tick = 1'b0;          // E3: length 2 -> 1
      repeat (4) step();                                 // N7
      trigger = 1'b1; len_tick = 1'b1;
      step();                                            // E8: step, tick, trigger
      trigger = 1'b0; len_tick = 1'b0;
      check("coincide_active", 32'(active), 32'd1);
      check("coincide_strobe", 32'(sample_strobe), 32'd1);
      check("coincide_pos0_sample", 32'(sample), 32'h3);
      repeat (3) step();
      check("coincide_no_early_strobe", 32'(sample_strobe), 32'd0);
      step();
      check("coincide_reload_strobe", 32'(sample_strobe), 32'd1);
      check("coincide_pos1_sample", 32'(sample), 32'h4);
      len_tick = 1'b1; step(); len_tick = 1'b0;
      check("coincide_len_reloaded", 32'(active), 32'd1);
      len_tick = 1'b1; step(); len_tick = 1'b0;
      check("coincide_len_expire", 32'(active), 32'd0);

      // Disable mid-play, then triggers with nr30[7]=0 are ignored
      nr30 = 8'h80; trigger = 1'b1; step(); trigger = 1'b0;
      repeat (6) step();
      check("midplay_active", 32'(active), 32'd1);
      nr30 = 8'h00; step();
      check("midplay_disable_active", 32'(active), 32'd0);
      check("midplay_disable_sample", 32'(sample), 32'd0);
      trigger = 1'b1; step(); trigger = 1'b0;
      check("ignored_trigger_active", 32'(active), 32'd0);
      check("ignored_trigger_strobe", 32'(sample_strobe), 32'd0);

      // Async reset between edges while playing bank 1 with nonzero rd_data
      nr30 = 8'hC0; rd_addr = 3'd0; trigger = 1'b1; step(); trigger = 1'b0;
      repeat (2) step();
      check("pre_reset_rd_data", 32'(rd_data), 32'h5634);
      check("pre_reset_active", 32'(active), 32'd1);
      check("pre_reset_sample", 32'(sample), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check("async_rd_data", 32'(rd_data), 32'd0);
      check("async_sample", 32'(sample), 32'd0);
      check("async_strobe", 32'(sample_strobe), 32'd0);
      check("async_active", 32'(active), 32'd0);
      step();
      reset_n = 1'b1;
      cpu_read("post_reset_bank0", 8'h40, 3'd0, 16'h0000);
      cpu_read("post_reset_bank1", 8'h00, 3'd7, 16'h0000);
      nr30 = 8'h80;
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (sample_strobe) strobes++;
      end
      check("post_reset_no_strobe", 32'(strobes), 32'd0);
      check("post_reset_inactive", 32'(active), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
